// File: rtl/cnn_pkg.sv
// Shared constants, pixel count and frame-state enum
// for the 5x5 sliding-window controller.
package cnn_pkg;

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 5;
  localparam int DEF_CW     = 5;
  localparam int DEF_PIX_N  = DEF_IMG_W * DEF_IMG_H;
  localparam int DEF_ADDR_W = $clog2(DEF_PIX_N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Control/window bundle between the sequencer (master)
// and the frame client / downstream window consumer (slave).
interface conv_window_ctrl_if
  import cnn_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CW     = DEF_CW
);

  logic              start;
  logic              win_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic              win_clken;
  logic              win_valid;
  logic [CW-1:0]     out_row;
  logic [CW-1:0]     out_col;

  modport master (
    input  start, win_ready,
    output busy, done, rom_addr, win_clken,
    output win_valid, out_row, out_col
  );

  modport slave (
    output start, win_ready,
    input  busy, done, rom_addr, win_clken,
    input  win_valid, out_row, out_col
  );

endinterface

// File: rtl/conv_pix_counter.sv
// Raster row/col counter with clear, enable, column wrap
// and a flag marking the last pixel of the frame.
module conv_pix_counter #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          col_end;

  assign col_end = (col_q == CW'(IMG_W - 1));
  assign last_o  = col_end && (row_q == CW'(IMG_H - 1));
  assign row_o   = row_q;
  assign col_o   = col_q;

  // Step one pixel in raster order; wrap column into row
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= last_o ? '0 : row_q + CW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer: ROM issue -> fetch/shift -> window valid.
// Define WIN_STRIDE2_EN to emit only even row/col windows.
module conv_window_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CW     = DEF_CW
) (
  input  logic               clk,
  input  logic               rstn,
  conv_window_ctrl_if.master bus
);

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fetch_vld_q;
  logic              fetch_ok_q;
  logic              fed_q;
  logic              win_vld_q;
  logic [CW-1:0]     orow_q;
  logic [CW-1:0]     ocol_q;

  logic          stall;
  logic          adv;
  logic          clr;
  logic          iss_en;
  logic          win_en;
  logic          iss_ok;
  logic [CW-1:0] ir;
  logic [CW-1:0] ic;
  logic [CW-1:0] wr;
  logic [CW-1:0] wc;
  logic          ilast;
  logic          wlast;

  assign stall  = win_vld_q & ~bus.win_ready;
  assign adv    = ~stall;
  assign clr    = (state_q == IDLE) & bus.start;
  assign iss_en = (state_q == RUN) & adv;
  assign win_en = fetch_vld_q & adv;

`ifdef WIN_STRIDE2_EN
  logic [CW-1:0] irow;
  logic [CW-1:0] icol;
  assign irow   = ir - CW'(K - 1);
  assign icol   = ic - CW'(K - 1);
  assign iss_ok = (ir >= CW'(K - 1)) && (ic >= CW'(K - 1))
               && !irow[0] && !icol[0];
`else
  assign iss_ok = (ir >= CW'(K - 1)) && (ic >= CW'(K - 1));
`endif

  conv_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_iss (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (clr),
    .en_i   (iss_en),
    .row_o  (ir),
    .col_o  (ic),
    .last_o (ilast)
  );

  conv_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_win (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (clr),
    .en_i   (win_en),
    .row_o  (wr),
    .col_o  (wc),
    .last_o (wlast)
  );

  // Frame FSM: issue address, fetch valid, busy/done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      fetch_vld_q <= 1'b0;
      fetch_ok_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        RUN: begin
          if (adv) begin
            fetch_vld_q <= 1'b1;
            fetch_ok_q  <= iss_ok;
            if (ilast) state_q <= DRAIN;
            else addr_q <= addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (adv) fetch_vld_q <= 1'b0;
          if (fed_q && (!win_vld_q || bus.win_ready)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Window stage: valid/coords held while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_vld_q <= 1'b0;
      orow_q    <= '0;
      ocol_q    <= '0;
      fed_q     <= 1'b0;
    end else begin
      if (clr) fed_q <= 1'b0;
      else if (win_en && wlast) fed_q <= 1'b1;
      if (adv) begin
        win_vld_q <= fetch_vld_q & fetch_ok_q;
        if (fetch_vld_q && fetch_ok_q) begin
          orow_q <= wr - CW'(K - 1);
          ocol_q <= wc - CW'(K - 1);
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rom_addr  = addr_q;
  assign bus.win_clken = fetch_vld_q & adv;
  assign bus.win_valid = win_vld_q;
  assign bus.out_row   = orow_q;
  assign bus.out_col   = ocol_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: window table,
// backpressure, ignored starts and mid-frame reset.
module tb_conv_window_ctrl;

  typedef struct {
    int idx;
    int row;
    int col;
    int rel;
  } vec_t;

`ifdef WIN_STRIDE2_EN
  localparam int NWIN   = 144;
  localparam int BP_R   = 4;
  localparam int BP_C   = 6;
  localparam int BP_NC  = 8;
  localparam int BP_A   = 236;
  localparam int LAST_R = 22;
  localparam int LAST_C = 22;
`else
  localparam int NWIN   = 576;
  localparam int BP_R   = 5;
  localparam int BP_C   = 7;
  localparam int BP_NC  = 8;
  localparam int BP_A   = 265;
  localparam int LAST_R = 23;
  localparam int LAST_C = 23;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  conv_window_ctrl_if #(.ADDR_W(10), .CW(5)) bus ();

  conv_window_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   s_cyc = 0;
  logic mon_clr = 1'b0;
  int   nwin = 0, ndone = 0, ndup = 0;
  int   done_rel = -1, busy_fall = -1;
  logic busy_prev = 1'b0;
  int   wr [1024];
  int   wc [1024];
  int   wt [1024];
  bit   seen [32][32];

  // Records every accepted window plus done/busy events
  always @(negedge clk) begin
    int rel;
    #1;
    rel = cyc - s_cyc + 1;
    if (mon_clr) begin
      nwin = 0;
      ndone = 0;
      ndup = 0;
      done_rel = -1;
      busy_fall = -1;
      busy_prev = 1'b0;
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          seen[r][c] = 1'b0;
    end else begin
      if (bus.win_valid && bus.win_ready) begin
        if (nwin < 1024) begin
          wr[nwin] = int'(bus.out_row);
          wc[nwin] = int'(bus.out_col);
          wt[nwin] = rel;
        end
        if (seen[bus.out_row][bus.out_col]) ndup++;
        seen[bus.out_row][bus.out_col] = 1'b1;
        nwin++;
      end
      if (bus.done) begin
        ndone++;
        done_rel = rel;
      end
      if (busy_prev && !bus.busy) busy_fall = rel;
      busy_prev = bus.busy;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #2;
    mon_clr = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    s_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input int lim);
    int n = 0;
    while (busy_fall < 0 && n < lim) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("frame_end_seen", int'(busy_fall >= 0), 1);
  endtask

  task automatic wait_win(input int r, input int c,
                          input int lim);
    int n = 0;
    while (!(bus.win_valid && int'(bus.out_row) == r
             && int'(bus.out_col) == c) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("window_seen", int'(n < lim), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_clken"}, int'(bus.win_clken), 0);
    chk({tag, "_valid"}, int'(bus.win_valid), 0);
    chk({tag, "_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_row"}, int'(bus.out_row), 0);
    chk({tag, "_col"}, int'(bus.out_col), 0);
  endtask

  vec_t tbl [6];

  initial begin
`ifdef WIN_STRIDE2_EN
    tbl[0] = '{0, 0, 0, 119};
    tbl[1] = '{1, 0, 2, 121};
    tbl[2] = '{11, 0, 22, 141};
    tbl[3] = '{12, 2, 0, 175};
    tbl[4] = '{78, 12, 12, 467};
    tbl[5] = '{143, 22, 22, 757};
`else
    tbl[0] = '{0, 0, 0, 119};
    tbl[1] = '{1, 0, 1, 120};
    tbl[2] = '{23, 0, 23, 142};
    tbl[3] = '{24, 1, 0, 147};
    tbl[4] = '{300, 12, 12, 467};
    tbl[5] = '{575, 23, 23, 786};
`endif

    rstn = 1'b0;
    bus.start = 1'b0;
    bus.win_ready = 1'b1;
    #8;
    chk_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Frame 1: ready tied high, table of windows
    clear_mon();
    start_frame();
    chk("f1_busy", int'(bus.busy), 1);
    chk("f1_addr0", int'(bus.rom_addr), 0);
    repeat (5) @(negedge clk);
    chk("f1_addr4", int'(bus.rom_addr), 4);
    wait_end(2000);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl%0d_row", i), wr[tbl[i].idx],
          tbl[i].row);
      chk($sformatf("tbl%0d_col", i), wc[tbl[i].idx],
          tbl[i].col);
      chk($sformatf("tbl%0d_cyc", i), wt[tbl[i].idx],
          tbl[i].rel);
    end
    chk("f1_nwin", nwin, NWIN);
    chk("f1_dup", ndup, 0);
    chk("f1_ndone", ndone, 1);
    chk("f1_done_cyc", done_rel, 787);
    chk("f1_busy_fall", busy_fall, 788);

    // Frame 2: backpressure and ignored starts
    clear_mon();
    start_frame();
    repeat (50) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_win(BP_R, BP_C, 2000);
    bus.win_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_valid", int'(bus.win_valid), 1);
      chk("bp_row", int'(bus.out_row), BP_R);
      chk("bp_col", int'(bus.out_col), BP_C);
      chk("bp_addr", int'(bus.rom_addr), BP_A);
      chk("bp_clken", int'(bus.win_clken), 0);
      @(negedge clk);
    end
    bus.win_ready = 1'b1;
    wait_win(LAST_R, LAST_C, 2000);
    bus.win_ready = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    #2;
    chk("late_busy", int'(bus.busy), 1);
    chk("late_hold", int'(bus.win_valid), 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.win_ready = 1'b1;
    wait_end(2000);
    begin
      int k = -1;
      for (int i = 0; i < NWIN && i < 1023; i++)
        if (k < 0 && wr[i] == BP_R && wc[i] == BP_C) k = i;
      chk("bp_found", int'(k >= 0), 1);
      if (k >= 0) begin
        chk("bp_next_row", wr[k + 1], BP_R);
        chk("bp_next_col", wc[k + 1], BP_NC);
      end
    end
    chk("f2_nwin", nwin, NWIN);
    chk("f2_dup", ndup, 0);
    chk("f2_done_cyc", done_rel, 792);
    repeat (20) @(negedge clk);
    chk("f2_idle", int'(bus.busy), 0);
    chk("f2_ndone", ndone, 1);

    // Frame 3: async reset mid-frame, then restart
    clear_mon();
    start_frame();
    repeat (40) @(negedge clk);
    rstn = 1'b0;
    #2;
    chk_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    clear_mon();
    start_frame();
    chk("f3_addr0", int'(bus.rom_addr), 0);
    wait_end(2000);
    chk("f3_nwin", nwin, NWIN);
    chk("f3_first_row", wr[0], 0);
    chk("f3_first_col", wc[0], 0);
    chk("f3_first_cyc", wt[0], 119);
    chk("f3_ndone", ndone, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Frame sequencer for the 5x5 sliding-window datapath: image ROM, then the line-buffer shift register, then the column-delay taps. Issues ROM addresses and the shift enable, and tracks pixel row and column. It asserts a window-valid only when a complete KxK window lies inside the image; windows that wrap across a row boundary are suppressed. It runs one frame per start pulse and honours downstream backpressure without losing or duplicating windows.

## Interface
- IMG_W, default 28: image width in pixels.
- IMG_H, default 28: image height in pixels.
- K, default 5: kernel size.
- ADDR_W, default 10: ROM address width; IMG_W*IMG_H must not exceed 2^ADDR_W.
- CW, default 5: coordinate width.
- clk, input, 1: single clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- start, input, 1: frame start pulse; sampled only in IDLE.
- win_ready, input, 1: downstream accepts the current window.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle pulse at frame end.
- rom_addr, output, ADDR_W: registered pixel address to the image ROM (1-cycle read latency).
- win_clken, output, 1: shift enable for the line buffer and tap chain.
- win_valid, output, 1: window taps are complete and aligned.
- out_row, output, CW: output-map row of the current window (top-left pixel row).
- out_col, output, CW: output-map column of the current window (top-left pixel column).

## Operation
- States:
  - IDLE: start goes to RUN.
  - RUN: one pixel issued per non-stalled cycle, addresses 0 to IMG_W*IMG_H-1 in raster order. After the last issue, go to DRAIN.
  - DRAIN: wait until the fetch stage is empty and the last window is accepted, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE.
- Pipeline stages:
  - Issue: rom_addr presented.
  - Fetch: ROM q is valid; win_clken=1 for that pixel.
  - Window: win_valid=1 in the cycle after the clken of pixel (r,c), if r>=K-1 and c>=K-1. In that case out_row=r-K+1 and out_col=c-K+1.
- Stall = win_valid & ~win_ready. During a stall:
  - rom_addr, the row/col counters and fetch-stage valid all hold.
  - win_clken is forced to 0.
  - win_valid, out_row and out_col hold.
  - The pending ROM word stays at q because the address is held, and it is shifted on release.
- Column counter wraps at IMG_W-1 to 0 and increments the row counter. The row counter reaching IMG_H-1 with column IMG_W-1 marks the last issue.
- Shift-register contents are not cleared between frames. Validity depends only on the counters, so stale rows are never emitted.
- Reset values: state IDLE; busy, done, win_clken, win_valid = 0; rom_addr, out_row, out_col = 0.

## Timing
- Let cycle S be the start edge. RUN begins at cycle S+1 and issues addr 0 at cycle S+1.
- Non-stalled latency from issue of pixel (r,c) to its win_valid is 2 cycles.
- First window (r,c)=(4,4), addr 116, issued at S+117; win_valid at S+119.
- Row gap: after output column IMG_W-K there are K-1 cycles with win_valid=0 before output column 0 of the next row.
- With win_ready tied high, the frame produces (IMG_H-K+1)*(IMG_W-K+1)=576 windows.
- done pulses in the cycle after the handshake of the last window; busy drops in the following cycle.
- An asynchronous reset mid-frame returns to IDLE with reset values. The next start begins again from addr 0.

## Configuration
- WIN_STRIDE2_EN:
  - When defined, win_valid is additionally gated so that out_row and out_col are both even. That gives 144 windows per frame for the defaults, and stalls apply only to gated-valid windows.
  - When undefined, stride is 1.

## Structure
- Shared package cnn_pkg holds:
  - IMG_W, IMG_H, K, ADDR_W defaults.
  - The state enum (IDLE, RUN, DRAIN, DONE).
  - A localparam for the pixel count.
- One sub-module, conv_pix_counter: the row/col raster counter with enable, wrap and last-pixel flag. It is instantiated twice: once for the issue stage and once for the window stage.

## Test plan
- Reset: assert rstn=0 mid-run -> all outputs 0, state IDLE; after release, start restarts at rom_addr 0.
- Full frame, win_ready=1 -> first win_valid at S+119 with (0,0); 576 valids total; last is (23,23); done pulses exactly once.
- Row boundary -> after (0,23), exactly 4 cycles with win_valid=0, then (1,0).
- Backpressure: win_ready=0 for 3 cycles while showing (5,7) -> win_valid, coordinates and rom_addr hold and win_clken=0. After release the next window is (5,8); the total is still 576 with no duplicate coordinates.
- start pulsed during RUN and DRAIN -> ignored; exactly one done per accepted start.
- With WIN_STRIDE2_EN: 144 windows, sequence (0,0), (0,2), ..., (0,22), (2,0); done after (22,22).
